// File: rtl/arb_pkg.sv
// Shared definitions for arbiter clients: one-hot FSM states and default widths.
package arb_pkg;

  localparam int unsigned DEF_LEN_W    = 8;
  localparam int unsigned DEF_WAIT_W   = 8;
  localparam int unsigned DEF_MAX_WAIT = 32;
  localparam int unsigned DEF_RETRIES  = 3;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    XFER    = 4'b0100,
    RELEASE = 4'b1000
  } state_e;

endpackage

// File: rtl/arb_requester_if.sv
// Command and arbiter handshake bundle of an arbiter client.
interface arb_requester_if
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             gnt;
  logic             req;
  logic             busy;
  logic             beat;
  logic             done;
  logic             timeout;
  logic             lost;

  // master: the requester agent; slave: the command source and arbiter side
  modport master (
    input  start, len, gnt,
    output req, busy, beat, done, timeout, lost
  );

  modport slave (
    output start, len, gnt,
    input  req, busy, beat, done, timeout, lost
  );

endinterface

// File: rtl/arb_wait_timer.sv
// Grant-wait counter: clear has priority over enable; expire flags MAX_WAIT-1.
module arb_wait_timer
  import arb_pkg::*;
#(
  parameter int unsigned WAIT_W   = DEF_WAIT_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (MAX_WAIT < 1 || MAX_WAIT >= (1 << WAIT_W)) begin : g_max_wait_range
    $error("MAX_WAIT must lie in 1..2**WAIT_W-1");
  end

  logic [WAIT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + WAIT_W'(1);
    end
  end

  assign expire = (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/arb_requester.sv
// Arbiter client agent: requests, counts granted beats, releases on completion.
// Optional ARB_REQ_RETRY_EN re-requests after a grant-wait timeout.
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter int unsigned WAIT_W   = DEF_WAIT_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned RETRIES  = DEF_RETRIES
) (
  input  logic            clock,
  input  logic            reset,
  arb_requester_if.master bus
);

  if (RETRIES > 16'hffff) begin : g_retries_range
    $error("RETRIES must fit in 16 bits");
  end

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             beat_q, beat_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             lost_q, lost_d;
  logic             timer_clear, timer_en, expire;

`ifdef ARB_REQ_RETRY_EN
  localparam int unsigned RETRY_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               retry_pend_q, retry_pend_d;
`endif

  arb_wait_timer #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (expire)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d     = state_q;
    rem_d       = rem_q;
    req_d       = req_q;
    busy_d      = busy_q;
    beat_d      = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    lost_d      = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
`ifdef ARB_REQ_RETRY_EN
    retry_cnt_d  = retry_cnt_q;
    retry_pend_d = retry_pend_q;
`endif

    case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
`ifdef ARB_REQ_RETRY_EN
        retry_cnt_d  = '0;
        retry_pend_d = 1'b0;
`endif
        if (bus.start && bus.len != '0) begin
          rem_d   = bus.len;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = REQ;
        end
      end

      REQ, XFER: begin
        if (bus.gnt) begin
          beat_d = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = RELEASE;
          end else begin
            state_d = XFER;
          end
        end else if (state_q == XFER) begin
          // Grant withdrawn mid-burst: the remaining beats are abandoned.
          req_d   = 1'b0;
          lost_d  = 1'b1;
          state_d = RELEASE;
        end else if (expire) begin
          req_d   = 1'b0;
          state_d = RELEASE;
`ifdef ARB_REQ_RETRY_EN
          if (retry_cnt_q != RETRY_W'(RETRIES)) begin
            retry_cnt_d  = retry_cnt_q + RETRY_W'(1);
            retry_pend_d = 1'b1;
          end else begin
            timeout_d = 1'b1;
          end
`else
          timeout_d = 1'b1;
`endif
        end else begin
          timer_en = 1'b1;
        end
      end

      RELEASE: begin
        // Wait out the arbiter's grant tail; those grants are not beats.
        if (!bus.gnt) begin
`ifdef ARB_REQ_RETRY_EN
          if (retry_pend_q) begin
            retry_pend_d = 1'b0;
            timer_clear  = 1'b1;
            req_d        = 1'b1;
            state_d      = REQ;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end

      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      beat_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      lost_q    <= lost_d;
    end
  end

`ifdef ARB_REQ_RETRY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      retry_cnt_q  <= '0;
      retry_pend_q <= 1'b0;
    end else begin
      retry_cnt_q  <= retry_cnt_d;
      retry_pend_q <= retry_pend_d;
    end
  end
`endif

  assign bus.req     = req_q;
  assign bus.busy    = busy_q;
  assign bus.beat    = beat_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.lost    = lost_q;

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side agent for the 2-input request/grant arbiter.
- Accepts a local burst command of N beats, raises req, waits for gnt, and counts granted beats.
- Releases req after the last beat, then waits for gnt to clear before accepting new work.
- One instance sits on each arbiter port; its req/gnt pins connect directly to the arbiter's req_x/gnt_x.

Parameters:
- LEN_W, 8, width of burst length and remaining-beat counter
- WAIT_W, 8, width of the grant-wait counter
- MAX_WAIT, 32, consecutive gnt-low cycles in REQ before timeout (1..2^WAIT_W-1)
- RETRIES, 3, extra request attempts after timeout (used only with ARB_REQ_RETRY_EN)

Ports:
- clock  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  command strobe, sampled only in IDLE
- len  input  LEN_W  burst length in beats, sampled with start
- gnt  input  1  grant from arbiter
- req  output  1  request to arbiter, registered
- busy  output  1  high from the cycle after start is accepted until return to IDLE
- beat  output  1  registered pulse, one per granted beat
- done  output  1  one-cycle pulse: all len beats granted
- timeout  output  1  one-cycle pulse: grant never arrived
- lost  output  1  one-cycle pulse: grant dropped mid-burst

Behaviour:
- Interface: one clock, clock; reset is synchronous, active-high, named reset.
- Reset:
  - state=IDLE; all outputs 0; counters 0.
  - Reset asserted mid-burst forces IDLE and req=0 at the next edge, with no done/lost/timeout pulse.
- States (one-hot):
  - IDLE=4'b0001, REQ=4'b0010, XFER=4'b0100, RELEASE=4'b1000.
- IDLE:
  - start=1 and len!=0 → rem<=len, wait_cnt<=0, req<=1, busy<=1, go REQ.
  - start with len=0 is ignored: no pulse, stays IDLE.
- Beat definition:
  - A beat is any cycle in REQ or XFER where gnt=1.
  - beat pulses on the following cycle.
  - rem decrements by 1 per beat.
- REQ:
  - gnt=1 → beat; go XFER, unless rem==1, which takes the last-beat path.
  - gnt=0 → wait_cnt++.
  - wait_cnt==MAX_WAIT-1 with gnt=0 → req<=0, timeout<=1, go RELEASE.
- XFER:
  - gnt=1 and rem>1 → beat, stay.
  - Last-beat path (gnt=1, rem==1, in REQ or XFER) → beat, req<=0, done<=1, go RELEASE.
  - gnt=0 → req<=0, lost<=1, go RELEASE; remaining beats are discarded.
- RELEASE:
  - Hold req=0 and busy=1.
  - Go IDLE on the first cycle with gnt=0. This covers the arbiter's 2-cycle grant tail.
  - gnt seen here is never counted as a beat.
  - start is ignored in RELEASE.
- Latency:
  - Against the arbiter, first gnt arrives 2 cycles after req rises.
  - An N-beat burst occupies N+4..N+5 cycles, start to busy low.
- Pulses:
  - done, timeout and lost are mutually exclusive and never coincide with reset.
  - beat may coincide with done: the last beat's pulse and done are asserted together.

Optional Feature:
- Macro: ARB_REQ_RETRY_EN.
- Defined:
  - A REQ timeout does not pulse timeout. It drops req, goes to RELEASE, and on gnt=0 returns to REQ (req<=1, wait_cnt<=0) instead of IDLE.
  - This repeats up to RETRIES times; timeout pulses only when the final attempt expires.
  - The retry counter is cleared in IDLE.
- Undefined:
  - Single attempt; no retry counter is synthesised.

Decomposition:
- Package arb_pkg holds:
  - state localparams IDLE/REQ/XFER/RELEASE (4-bit one-hot)
  - default LEN_W, WAIT_W, MAX_WAIT
- Sub-module arb_wait_timer holds:
  - the WAIT_W counter with clear/enable inputs and an expire output at MAX_WAIT-1
  - reused by future arbiter clients.

Test Plan:
- Basic burst: reset 2 cycles; start with len=3, arbiter idle → req rises at t+1, gnt at t+3, beats at t+4..t+6, done at t+6, req low at t+6, busy low once gnt=0.
- Timeout: gnt tied 0, MAX_WAIT=4, start with len=5 → req high 4 cycles, timeout pulse once, zero beats, busy low 1 cycle later.
- Grant loss: len=8, force gnt low after 3 beats → exactly 3 beat pulses, lost=1, done never asserted, req=0 next cycle.
- Two instances on the arbiter: start both with len=2 the same cycle → port-0 done first, port-1 granted only after port-0 grant clears, 4 total beats, no overlap of gnt_0/gnt_1.
- Reset mid-XFER at beat 2 of len=6 → next cycle req=0, busy=0, no done/lost; new start with len=1 then completes normally.
- Edge and retry cases:
  - len=0 start → no activity.
  - len=1 → one beat coincides with done.
  - With ARB_REQ_RETRY_EN, RETRIES=2 and gnt stuck 0 → req raised 3 times, one timeout pulse.
